aes_req_scheduler: RTL

Arbitrates and sequences the shared AES encryption core between two block requesters. Handles post-reset key warm-up, grants one requester per block through a valid/ready handshake, and latches the selected 128-bit block into the core's word inputs. Holds the core load strobe for the core's fixed latency, then returns the result to the granted requester. Sits between the requester front-ends and the core/key-expansion pair, replacing free-running input fetch timing with demand-driven scheduling.

---
 rtl/aes_req_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/aes_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : aes_req_scheduler
// Purpose  : Schedules a shared AES core between two block requesters.
//            Runs a post-reset key warm-up (one key_rst pulse), grants one
//            requester per block over valid/ready, latches the 128-bit block
//            into the core word inputs, holds core_load for CORE_LAT cycles
//            and returns the captured result with a one-cycle response pulse.
// Options  : `define AES_SCHED_RR_EN selects round-robin arbitration;
//            otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module aes_req_scheduler #(
    parameter int CORE_LAT   = 16,   // core_load high cycles per block, 1..255
    parameter int KEY_WARMUP = 18    // cycle of the key_rst pulse after reset, 1..255
) (
    input  logic         clk,
    input  logic         rst,        // asynchronous, active-low
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic [31:0]  core_x,
    output logic [31:0]  core_y,
    output logic [31:0]  core_z,
    output logic [31:0]  core_w,
    output logic         core_load,
    input  logic [127:0] core_res,
    output logic         key_rst,
    output logic [127:0] rsp_data,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_WARM = 2'd0,
        S_IDLE = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [7:0] c_WARM_LAST = 8'(KEY_WARMUP - 1);
    localparam logic [7:0] c_RUN_LAST  = 8'(CORE_LAT - 1);

    state_t         r_state;
    logic [7:0]     r_warm_ctr;
    logic [7:0]     r_run_ctr;
    logic           r_grant;
    logic           r_last;
    logic [31:0]    r_core_x;
    logic [31:0]    r_core_y;
    logic [31:0]    r_core_z;
    logic [31:0]    r_core_w;
    logic           r_core_load;
    logic [127:0]   r_rsp_data;
    logic           r_rsp0_valid;
    logic           r_rsp1_valid;

    logic           w_sel;
    logic           w_xfer;
    logic [127:0]   w_sel_data;

    // Arbitration: pick which valid requester is offered ready in IDLE
    always_comb begin
        w_sel = 1'b0;
`ifdef AES_SCHED_RR_EN
        if (req0_valid && req1_valid) begin
            w_sel = ~r_last;
        end else if (req1_valid) begin
            w_sel = 1'b1;
        end
`else
        if (!req0_valid && req1_valid) begin
            w_sel = 1'b1;
        end
`endif
    end

`ifndef AES_SCHED_RR_EN
    // Last-served tracking is kept in fixed-priority builds but not consulted.
    logic w_unused_last;
    assign w_unused_last = r_last;
`endif

    // w_sel always points at a valid requester when any is valid
    assign w_xfer     = (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign w_sel_data = w_sel ? req1_data : req0_data;

    assign req0_ready = (r_state == S_IDLE) && req0_valid && (w_sel == 1'b0);
    assign req1_ready = (r_state == S_IDLE) && req1_valid && (w_sel == 1'b1);

    // Main sequencer: warm-up, grant/latch, run timing, result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_WARM;
            r_warm_ctr   <= 8'd0;
            r_run_ctr    <= 8'd0;
            r_grant      <= 1'b0;
            r_last       <= 1'b1;
            r_core_x     <= 32'd0;
            r_core_y     <= 32'd0;
            r_core_z     <= 32'd0;
            r_core_w     <= 32'd0;
            r_core_load  <= 1'b0;
            r_rsp_data   <= 128'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                S_WARM: begin
                    if (r_warm_ctr == c_WARM_LAST) begin
                        r_warm_ctr <= 8'd0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_warm_ctr <= r_warm_ctr + 8'd1;
                    end
                end
                S_IDLE: begin
                    if (w_xfer) begin
                        r_core_x    <= w_sel_data[127:96];
                        r_core_y    <= w_sel_data[95:64];
                        r_core_z    <= w_sel_data[63:32];
                        r_core_w    <= w_sel_data[31:0];
                        r_grant     <= w_sel;
                        r_core_load <= 1'b1;
                        r_run_ctr   <= 8'd0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_run_ctr == c_RUN_LAST) begin
                        r_core_load  <= 1'b0;
                        r_rsp_data   <= core_res;
                        r_rsp0_valid <= ~r_grant;
                        r_rsp1_valid <= r_grant;
                        r_last       <= r_grant;
                        r_run_ctr    <= 8'd0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_run_ctr <= r_run_ctr + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_WARM;
                end
            endcase
        end
    end

    generate
        if (KEY_WARMUP == 1) begin : g_key_rst_comb
            // Pulse must appear in the very first cycle after release, which a
            // register cannot produce; decode state and mask while in reset.
            assign key_rst = rst && (r_state == S_WARM) && (r_warm_ctr == 8'd0);
        end else begin : g_key_rst_reg
            localparam logic [7:0] c_KEY_PRE = 8'(KEY_WARMUP - 2);
            logic r_key_rst;
            // Registered pulse, armed one cycle ahead of the target warm cycle
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_key_rst <= 1'b0;
                end else begin
                    r_key_rst <= (r_state == S_WARM) && (r_warm_ctr == c_KEY_PRE);
                end
            end
            assign key_rst = r_key_rst;
        end
    endgenerate

    assign core_x     = r_core_x;
    assign core_y     = r_core_y;
    assign core_z     = r_core_z;
    assign core_w     = r_core_w;
    assign core_load  = r_core_load;
    assign rsp_data   = r_rsp_data;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
